// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide unit: op encodings and FSM states.
// The instruction decoder drives op using these same constants.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } md_state_e;

  localparam int unsigned MdIters = 32;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide writing the HI and LO registers.
// Launch edge, 32 shared iterations, then one sign-fix edge: busy for 33 cycles.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        div_zero_q, div_zero_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Multiply step: {carry, upper + multiplicand} shifted right with the multiplier bits.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  // Divide step: 33-bit partial remainder compared against the divisor.
  logic [32:0] div_rem;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  logic        in_signed;
  logic        in_sign_a;
  logic        in_sign_b;
  logic [63:0] prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_rem  = {acc_q[63:32], acc_q[31]};
    div_diff = {1'b0, div_rem} - {2'b00, opnd_q};
    div_ge   = ~div_diff[33];
    div_next = {(div_ge ? div_diff[31:0] : div_rem[31:0]), acc_q[30:0], div_ge};
  end

  assign in_signed = ~op[0];
  assign in_sign_a = in_signed & a[31];
  assign in_sign_b = in_signed & b[31];
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? neg64(acc_q) : acc_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Multiply and divide both start from {0, |a|} with |b| as the side operand.
          op_d       = md_op_e'(op);
          sign_a_d   = in_sign_a;
          sign_b_d   = in_sign_b;
          div_zero_d = (b == 32'd0);
          acc_d      = {32'd0, (in_sign_a ? neg32(a) : a)};
          opnd_d     = in_sign_b ? neg32(b) : b;
          cnt_d      = 5'd0;
          state_d    = StRun;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      StRun: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MdIters - 1)) state_d = StFix;
      end
      StFix: begin
        if (op_q[1]) begin
          // Zero divisor: remainder path already yields a; quotient is forced to all ones.
          lo_d = div_zero_q ? 32'hFFFF_FFFF
               : ((sign_a_q ^ sign_b_q) ? neg32(acc_q[31:0]) : acc_q[31:0]);
          hi_d = sign_a_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= MD_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// plus directed cases with literal expected results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles of busy remaining, architectural HI/LO, pending result.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        cmp_en = 1'b0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {HI, LO} from the architectural definition of each op.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0]        p;
    logic signed [31:0] sx, sy, q, r;
    case (o)
      2'b00: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      2'b01: p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (o == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          p = {32'd0, 32'h8000_0000};
        else if (o == 2'b10) begin
          sx = x; sy = y; q = sx / sy; r = sx % sy;
          p = {r, q};
        end else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start) begin
      {p_hi, p_lo} <= ref_op(op, a, b);
      m_left       <= 33;
    end else begin
      if (mthi) m_hi <= wdata;
      if (mtlo) m_lo <= wdata;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en && !rst) begin
      chk("model_busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return $urandom_range(0, 200);
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) chk("done_timeout", 32'(cyc), 32'd33);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("multu_busy_cycles", 32'(cyc), 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(cyc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(2'b11, 32'h0000_0064, 32'd0);
    wait_done(cyc);
    chk("divu_zero_cycles", 32'(cyc), 32'd33);
    chk("divu_zero_hi", hi, 32'h0000_0064);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    // Start and mthi while busy must both be dropped.
    issue(2'b10, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2; mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(cyc);
    chk("busy_ignore_lo", lo, 32'd14);
    chk("busy_ignore_hi", hi, 32'd2);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("idle_mthi_hi", hi, 32'h1234);
    chk("idle_mthi_lo", lo, 32'd14);

    // Asynchronous abort partway through a multiply.
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01, 32'd3, 32'd4);
    wait_done(cyc);
    chk("post_abort_lo", lo, 32'd12);
    chk("post_abort_hi", hi, 32'd0);

    // Random traffic: inputs change every cycle, model checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      mthi  = ($urandom_range(0, 3) == 0);
      mtlo  = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
